// File: rtl/uart_mmio_responder_pkg.sv
// Shared constants and types for the memory-mapped UART responder:
// register addresses, status bit positions and the TX FSM state encoding.
package uart_mmio_pkg;

  localparam logic [31:0] ADDR_DATA_DEFAULT = 32'hBFD003F8;
  localparam logic [31:0] ADDR_STAT_DEFAULT = 32'hBFD003FC;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_TX_OVF   = 2;
  localparam int STAT_RX_OVF   = 3;

  // Cycles the TX FSM waits for the transmitter to report busy (count is 0-based).
  localparam logic [1:0] TX_WAIT_LAST = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WAIT  = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_mmio_responder_if.sv
// CPU data_sram bus as seen by the UART responder; the CPU side is the
// master, the responder is the slave.
interface uart_mmio_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;

  modport master (output en, output wen, output addr, output wdata, input rdata, input sel);
  modport slave  (input en, input wen, input addr, input wdata, output rdata, output sel);
endinterface

// File: rtl/uart_mmio_responder_sync_fifo.sv
// Circular-buffer FIFO with extra-MSB wrap pointers. A pop on an empty FIFO
// is ignored, and a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_10M,
  input  logic             reset_of_clk10M,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; the MSB distinguishes full from empty.
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk_10M) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// UART responder on the CPU data_sram bus: data/status register decode,
// RX/TX byte FIFOs and the FSM that feeds async_transmitter.
module uart_mmio_responder
  import uart_mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_DATA  = ADDR_DATA_DEFAULT,
  parameter logic [31:0] ADDR_STAT  = ADDR_STAT_DEFAULT
) (
  input  logic                   clk_10M,
  input  logic                   reset_of_clk10M,
  uart_mmio_responder_if.slave   bus,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  output logic                   rx_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        hit_data_s, hit_stat_s, is_read_s;
  logic        rx_pop_s, rx_full_s, rx_empty_s;
  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [7:0]  rx_dout_s, tx_dout_s;
  logic [AW:0] rx_count_s, tx_count_s;
  logic        tx_ovf_r, rx_ovf_r;
  logic        tx_ovf_set_s, rx_ovf_set_s, stat_rd_s;
  logic [31:0] status_s;
  tx_state_t   state_r;
  logic [1:0]  wait_cnt_r;
  logic        tx_start_r;
  logic [7:0]  tx_data_r;

  assign hit_data_s = bus.en & (bus.addr[31:2] == ADDR_DATA[31:2]);
  assign hit_stat_s = bus.en & (bus.addr[31:2] == ADDR_STAT[31:2]);
  assign is_read_s  = (bus.wen == 4'b0000);
  assign bus.sel    = hit_data_s | hit_stat_s;

  assign rx_clear   = rx_ready;
  assign rx_pop_s   = hit_data_s & is_read_s;
  assign tx_push_s  = hit_data_s & bus.wen[0];
  assign tx_pop_s   = (state_r == TX_IDLE) & ~tx_empty_s & ~tx_busy;
  assign stat_rd_s  = hit_stat_s & is_read_s;

  // A full FIFO still takes a byte when a pop frees a slot in the same cycle.
  assign tx_ovf_set_s = tx_push_s & tx_full_s & ~tx_pop_s;
  assign rx_ovf_set_s = rx_ready & rx_full_s & ~rx_pop_s;

  assign status_s = {28'h0000000, rx_ovf_r, tx_ovf_r, ~rx_empty_s, ~tx_full_s};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_10M(clk_10M), .reset_of_clk10M(reset_of_clk10M),
    .push(rx_ready), .pop(rx_pop_s), .din(rx_data), .dout(rx_dout_s),
    .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_10M(clk_10M), .reset_of_clk10M(reset_of_clk10M),
    .push(tx_push_s), .pop(tx_pop_s), .din(bus.wdata[7:0]), .dout(tx_dout_s),
    .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
  );

  // Load data mux; non-matching addresses and writes read as zero.
  always_comb begin
    bus.rdata = 32'h00000000;
    if (hit_data_s && is_read_s) begin
      bus.rdata = {24'h000000, rx_dout_s};
    end else if (stat_rd_s) begin
      bus.rdata = status_s;
    end else begin
      bus.rdata = 32'h00000000;
    end
  end

  // Sticky overflow flags: a status read clears them, a new overflow wins.
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      tx_ovf_r <= 1'b0;
      rx_ovf_r <= 1'b0;
    end else begin
      tx_ovf_r <= (tx_ovf_r & ~stat_rd_s) | tx_ovf_set_s;
      rx_ovf_r <= (rx_ovf_r & ~stat_rd_s) | rx_ovf_set_s;
    end
  end

  // TX FSM: launch a byte, wait briefly for busy, then drain until idle.
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      state_r    <= TX_IDLE;
      wait_cnt_r <= 2'd0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      case (state_r)
        TX_IDLE: begin
          wait_cnt_r <= 2'd0;
          if (tx_pop_s) begin
            tx_data_r  <= tx_dout_s;
            tx_start_r <= 1'b1;
            state_r    <= TX_WAIT;
          end else begin
            tx_start_r <= 1'b0;
          end
        end
        TX_WAIT: begin
          tx_start_r <= 1'b0;
          if (tx_busy) begin
            state_r <= TX_DRAIN;
          end else if (wait_cnt_r == TX_WAIT_LAST) begin
            state_r <= TX_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        TX_DRAIN: begin
          tx_start_r <= 1'b0;
          if (!tx_busy) state_r <= TX_IDLE;
        end
        default: begin
          tx_start_r <= 1'b0;
          state_r    <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Scoreboard bench for uart_mmio_responder: expected TX bytes and RX load
// values are queued at stimulus time and compared when the DUT produces them.
module tb_uart_mmio_responder;

  localparam logic [31:0] A_DATA  = 32'hBFD003F8;
  localparam logic [31:0] A_STAT  = 32'hBFD003FC;
  localparam logic [31:0] A_OTHER = 32'hBFD00400;

  logic       clk_10M = 1'b0;
  logic       reset_of_clk10M;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_clear;

  int         checks = 0;
  int         failures = 0;
  int         tx_starts = 0;
  int         busy_cnt = 0;
  bit         busy_force = 1'b0;
  bit         busy_model_en = 1'b1;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  uart_mmio_responder_if bus ();

  uart_mmio_responder #(.FIFO_DEPTH(4)) dut (
    .clk_10M(clk_10M), .reset_of_clk10M(reset_of_clk10M), .bus(bus),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_clear(rx_clear)
  );

  always #50 clk_10M = ~clk_10M;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic        s;
    @(negedge clk_10M);
    bus.en = 1'b1; bus.wen = 4'b0000; bus.addr = addr; bus.wdata = 32'h0;
    #1 d = bus.rdata; s = bus.sel;
    check_val(tag, d, exp);
    check_val({tag, "_sel"}, {31'h0, s}, {31'h0, (addr == A_DATA) || (addr == A_STAT)});
    @(posedge clk_10M);
    #1 bus.en = 1'b0;
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] exp;
    exp = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
    read_check(A_DATA, exp, tag);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    @(negedge clk_10M);
    bus.en = 1'b1; bus.wen = wen; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk_10M);
    #1 bus.en = 1'b0; bus.wen = 4'b0000;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk_10M);
    rx_ready = 1'b1; rx_data = b;
    #1 check_val("rx_clear_high", {31'h0, rx_clear}, 32'h1);
    @(posedge clk_10M);
    #1 rx_ready = 1'b0;
  endtask

  // RX byte arriving in the same cycle as a CPU data load.
  task automatic rx_and_read(input logic [7:0] b, input logic [31:0] exp, input string tag);
    @(negedge clk_10M);
    rx_ready = 1'b1; rx_data = b;
    bus.en = 1'b1; bus.wen = 4'b0000; bus.addr = A_DATA;
    #1 check_val(tag, bus.rdata, exp);
    @(posedge clk_10M);
    #1 rx_ready = 1'b0; bus.en = 1'b0;
  endtask

  task automatic wait_tx_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_10M);
      if (tx_q.size() == 0 && busy_cnt == 0 && !busy_force) begin
        done = 1'b1;
        break;
      end
    end
    check_val(tag, {31'h0, done}, 32'h1);
    repeat (4) @(negedge clk_10M);
  endtask

  // Transmitter model and TX scoreboard consumer.
  initial begin
    logic prev_start;
    logic prev_busy;
    prev_start = 1'b0;
    prev_busy  = 1'b0;
    tx_busy    = 1'b0;
    forever begin
      @(negedge clk_10M);
      if (prev_start) check_val("tx_start_width", {31'h0, tx_start}, 32'h0);
      if (tx_start) begin
        tx_starts++;
        check_val("tx_start_while_busy", {31'h0, prev_busy}, 32'h0);
        check_val("tx_q_nonempty", {31'h0, tx_q.size() != 0}, 32'h1);
        if (tx_q.size() != 0) check_val("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
        if (busy_model_en) busy_cnt = 10;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy    = busy_force || (busy_cnt != 0);
      prev_start = tx_start;
      prev_busy  = tx_busy;
    end
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int start0;
    bus.en = 1'b0; bus.wen = 4'b0000; bus.addr = 32'h0; bus.wdata = 32'h0;
    rx_ready = 1'b0; rx_data = 8'h00;
    reset_of_clk10M = 1'b1;
    repeat (3) @(negedge clk_10M);
    #1 check_val("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check_val("rst_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge clk_10M) reset_of_clk10M = 1'b0;

    read_check(A_STAT, 32'h1, "stat_reset");
    read_check(A_DATA, 32'h0, "data_empty");
    read_check(A_STAT, 32'h1, "stat_after_empty_read");

    // Foreign addresses and status writes must not touch state.
    rx_byte(8'h3C); rx_q.push_back(8'h3C);
    read_check(A_OTHER, 32'h0, "other_addr_read");
    bus_write(A_OTHER, 4'b1111, 32'h000000AA);
    bus_write(A_STAT, 4'b1111, 32'h000000FF);
    bus_write(A_DATA, 4'b0010, 32'h0000BB00);
    read_check(A_STAT, 32'h3, "stat_no_side_effect");
    read_rx("rx_after_other");

    // Single byte latency, then back-to-back bytes gated by busy.
    start0 = tx_starts;
    tx_q.push_back(8'h41);
    bus_write(A_DATA, 4'b0001, 32'h00000041);
    @(negedge clk_10M);
    check_val("tx_lat_early", {31'h0, tx_start}, 32'h0);
    @(negedge clk_10M);
    check_val("tx_lat_start", {31'h0, tx_start}, 32'h1);
    check_val("tx_lat_data", {24'h0, tx_data}, 32'h41);
    tx_q.push_back(8'h42);
    bus_write(A_DATA, 4'b0001, 32'h00000042);
    wait_tx_done("tx_two_done");
    check_val("tx_two_count", tx_starts - start0, 32'd2);

    // TX overflow with the transmitter held busy.
    busy_force = 1'b1;
    repeat (2) @(negedge clk_10M);
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'h10 + 8'(i));
      bus_write(A_DATA, 4'b0001, 32'h10 + i);
    end
    read_check(A_STAT, 32'h0, "stat_tx_full");
    bus_write(A_DATA, 4'b0001, 32'h00000014);
    read_check(A_STAT, 32'h4, "stat_tx_ovf");
    read_check(A_STAT, 32'h0, "stat_tx_ovf_cleared");
    start0 = tx_starts;
    busy_force = 1'b0;
    wait_tx_done("tx_ovf_drain_done");
    check_val("tx_ovf_count", tx_starts - start0, 32'd4);
    read_check(A_STAT, 32'h1, "stat_tx_idle");

    // RX ordering.
    rx_byte(8'hA5); rx_q.push_back(8'hA5);
    rx_byte(8'h5A); rx_q.push_back(8'h5A);
    read_check(A_STAT, 32'h3, "stat_rx_avail");
    read_rx("rx_first");
    read_rx("rx_second");
    read_check(A_STAT, 32'h1, "stat_rx_drained");

    // RX overflow, then push concurrent with pop on a full FIFO.
    for (int i = 0; i < 5; i++) begin
      rx_byte(8'h80 + 8'(i));
      if (i < 4) rx_q.push_back(8'h80 + 8'(i));
    end
    read_check(A_STAT, 32'hB, "stat_rx_ovf");
    rx_and_read(8'h77, {24'h0, rx_q.pop_front()}, "rx_full_pop");
    rx_q.push_back(8'h77);
    read_check(A_STAT, 32'h3, "stat_full_push_pop");
    for (int i = 0; i < 4; i++) read_rx("rx_ovf_drain");
    read_check(A_STAT, 32'h1, "stat_rx_empty");
    read_check(A_DATA, 32'h0, "data_empty_again");

    // Reset while the FSM waits for busy, with RX bytes buffered.
    for (int i = 0; i < 3; i++) rx_byte(8'hC0 + 8'(i));
    busy_model_en = 1'b0;
    tx_q.push_back(8'h55);
    bus_write(A_DATA, 4'b0001, 32'h00000055);
    @(negedge clk_10M);
    @(negedge clk_10M);
    check_val("wait_entry_start", {31'h0, tx_start}, 32'h1);
    #10 reset_of_clk10M = 1'b1;
    #1 check_val("midrst_tx_start", {31'h0, tx_start}, 32'h0);
    check_val("midrst_tx_data", {24'h0, tx_data}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_10M);
      check_val("midrst_hold", {31'h0, tx_start}, 32'h0);
    end
    reset_of_clk10M = 1'b0;
    @(posedge clk_10M);
    #1 check_val("rst_release_start", {31'h0, tx_start}, 32'h0);
    rx_q.delete();
    busy_model_en = 1'b1;
    read_check(A_STAT, 32'h1, "stat_after_midrst");
    read_check(A_DATA, 32'h0, "data_after_midrst");
    repeat (6) @(negedge clk_10M);
    check_val("tx_q_empty_end", tx_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
